freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 18 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/freq_meter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared FSM state type, default constants and sizing helper for freq_meter
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GATE_CYCLES_DEF = 100_000_000;
    localparam int CNT_W_DEF       = 16;

    // Gate counter width; a one-cycle gate still needs a 1-bit counter.
    function automatic int gate_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 2-FF synchronizer, history register and registered rising-edge pulse
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic meta;
    logic sync;
    logic hist;

    // Registering the pulse gives a fixed 3-cycle latency from an input rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
            rise <= 1'b0;
        end else begin
            meta <= d_async;
            sync <= meta;
            hist <= sync;
            rise <= sync & ~hist;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter frequency meter; FREQ_METER_PERIOD_EN adds period_out
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int CONTINUOUS  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [31:0]      period_out
`endif
);

    localparam int GW = gate_w(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic             ovf_int;
    logic             ovf_nxt;
    logic             rise;
    logic             gate_last;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (sig_in),
        .rise    (rise)
    );

    assign gate_last = (gate_cnt == GATE_LAST);

    // Saturating edge count; an edge arriving at full scale flags overflow.
    always_comb begin
        edge_nxt = edge_cnt;
        ovf_nxt  = ovf_int;
        if (rise) begin
            if (&edge_cnt) begin
                ovf_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = GATE;
            GATE:    if (gate_last) state_nxt = DONE;
            DONE:    state_nxt = (CONTINUOUS != 0) ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            ovf_int   <= 1'b0;
            count_out <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_int  <= 1'b0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_last ? '0 : gate_cnt + GW'(1);
                    edge_cnt <= edge_nxt;
                    ovf_int  <= ovf_nxt;
                    // Result includes an edge seen in the final gate cycle.
                    if (gate_last) begin
                        count_out <= edge_nxt;
                        overflow  <= ovf_nxt;
                    end
                end
                DONE: begin
                    // Edges in this cycle belong to neither window.
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf_int  <= 1'b0;
                end
                default: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf_int  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = (state == GATE);
    assign count_valid = (state == DONE);

`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] since_edge;

    // since_edge equals the cycle distance to the previous edge when a new one arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            since_edge <= '0;
            period_out <= '0;
        end else if (rise) begin
            period_out <= since_edge;
            since_edge <= 32'd1;
        end else if (~&since_edge) begin
            since_edge <= since_edge + 32'd1;
        end
    end
`endif

endmodule
